// File: rtl/axil_apb_bridge_n.sv
// axil_apb_bridge_n: AXI4-Lite slave to APB4 master bridge.
// One outstanding transaction, one-hot PSEL to SLV_NUM slaves decoded from
// REGION_LO/REGION_HI (lowest matching index wins), DECERR for unmapped
// addresses, SLVERR from PSLVERR, fair read/write alternation on contention.
// Optional feature macro: AXIL_APB_TIMEOUT_EN (ACCESS-phase watchdog that
// abandons a transfer after TIMEOUT_CYC cycles with SLVERR).
module axil_apb_bridge_n #(
    parameter int SLV_NUM = 8,
    parameter logic [32*SLV_NUM-1:0] REGION_LO = {
        32'h0300_7000, 32'h0300_6000, 32'h0300_5000, 32'h0300_4000,
        32'h0300_3000, 32'h0300_2000, 32'h0300_1000, 32'h0300_0000},
    parameter logic [32*SLV_NUM-1:0] REGION_HI = {
        32'h0300_7FFF, 32'h0300_6FFF, 32'h0300_5FFF, 32'h0300_4FFF,
        32'h0300_3FFF, 32'h0300_2FFF, 32'h0300_1FFF, 32'h0300_0FFF},
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_awaddr,
    input  logic [2:0]            s_awprot,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [31:0]           s_araddr,
    input  logic [2:0]            s_arprot,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic [31:0]           m_paddr,
    output logic [2:0]            m_pprot,
    output logic [SLV_NUM-1:0]    m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [31:0]           m_pwdata,
    output logic [3:0]            m_pstrb,
    input  logic [SLV_NUM-1:0]    m_pready,
    input  logic [32*SLV_NUM-1:0] m_prdata,
    input  logic [SLV_NUM-1:0]    m_pslverr
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_RESP_W = 3'd3;
    localparam logic [2:0] ST_RESP_R = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [2:0]         state_r;
    logic               last_write_r;
    logic               alive_r;
    logic [31:0]        m_paddr_r;
    logic [2:0]         m_pprot_r;
    logic [SLV_NUM-1:0] m_psel_r;
    logic               m_penable_r;
    logic               m_pwrite_r;
    logic [31:0]        m_pwdata_r;
    logic [3:0]         m_pstrb_r;
    logic               s_bvalid_r;
    logic [1:0]         s_bresp_r;
    logic               s_rvalid_r;
    logic [1:0]         s_rresp_r;
    logic [31:0]        s_rdata_r;

    logic               wr_cand_s;
    logic               rd_cand_s;
    logic               grant_w_s;
    logic               grant_r_s;
    logic [31:0]        req_addr_s;
    logic [SLV_NUM-1:0] match_s;
    logic [SLV_NUM-1:0] dec_sel_s;
    logic               dec_hit_s;
    logic               pready_s;
    logic               pslverr_s;
    logic [31:0]        prdata_s;
    logic [1:0]         acc_resp_s;
    logic               timeout_hit_s;

    // Only the selected slave's completion signals are considered.
    assign pready_s  = |(m_pready & m_psel_r);
    assign pslverr_s = |(m_pslverr & m_psel_r);

    // Arbitrate between a complete write (AW+W) and a read; readies stay low until the first clock after reset.
    always_comb begin
        wr_cand_s = s_awvalid & s_wvalid;
        rd_cand_s = s_arvalid;
        if (alive_r && (state_r == ST_IDLE)) begin
            grant_w_s = wr_cand_s & (~rd_cand_s | ~last_write_r);
            grant_r_s = rd_cand_s & (~wr_cand_s | last_write_r);
        end else begin
            grant_w_s = 1'b0;
            grant_r_s = 1'b0;
        end
        if (grant_w_s) begin
            req_addr_s = s_awaddr;
        end else begin
            req_addr_s = s_araddr;
        end
    end

    // Address decode: all matching regions, then isolate the lowest set bit.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            match_s[i] = (req_addr_s >= REGION_LO[32*i +: 32]) &&
                         (req_addr_s <= REGION_HI[32*i +: 32]);
        end
        dec_sel_s = match_s & (~match_s + SLV_NUM'(1));
        dec_hit_s = |match_s;
    end

    // Read data mux driven by the registered one-hot select.
    always_comb begin
        prdata_s = 32'h0000_0000;
        for (int i = 0; i < SLV_NUM; i++) begin
            prdata_s = prdata_s | (m_prdata[32*i +: 32] & {32{m_psel_r[i]}});
        end
    end

    // Completion response: slave status on PREADY, otherwise the transfer was abandoned.
    always_comb begin
        if (pready_s) begin
            acc_resp_s = pslverr_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
            acc_resp_s = RESP_SLVERR;
        end
    end

`ifdef AXIL_APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt_r;

    // The cycle that would bring the counter to TIMEOUT_CYC abandons the transfer; PREADY wins.
    assign timeout_hit_s = (state_r == ST_ACCESS) && !pready_s && (tmo_cnt_r == TMO_LAST);

    // ACCESS-phase wait counter: cleared in SETUP, counts ACCESS cycles without PREADY.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ST_SETUP) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_ACCESS) && !pready_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
    end
`else
    logic [15:0] tmo_unused_s;

    // Without the watchdog, ACCESS waits for PREADY indefinitely and the limit has no consumer.
    assign timeout_hit_s = 1'b0;
    assign tmo_unused_s  = 16'(TIMEOUT_CYC);
`endif

    // Transaction FSM and all registered AXI/APB outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            last_write_r <= 1'b1;
            alive_r      <= 1'b0;
            m_paddr_r    <= 32'h0000_0000;
            m_pprot_r    <= 3'b000;
            m_psel_r     <= '0;
            m_penable_r  <= 1'b0;
            m_pwrite_r   <= 1'b0;
            m_pwdata_r   <= 32'h0000_0000;
            m_pstrb_r    <= 4'h0;
            s_bvalid_r   <= 1'b0;
            s_bresp_r    <= 2'b00;
            s_rvalid_r   <= 1'b0;
            s_rresp_r    <= 2'b00;
            s_rdata_r    <= 32'h0000_0000;
        end else begin
            alive_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (grant_w_s || grant_r_s) begin
                        last_write_r <= grant_w_s;
                        m_paddr_r    <= req_addr_s;
                        m_pprot_r    <= grant_w_s ? s_awprot : s_arprot;
                        m_pwrite_r   <= grant_w_s;
                        m_pstrb_r    <= grant_w_s ? s_wstrb : 4'h0;
                        if (grant_w_s) begin
                            m_pwdata_r <= s_wdata;
                        end
                        if (dec_hit_s) begin
                            m_psel_r <= dec_sel_s;
                            state_r  <= ST_SETUP;
                        end else if (grant_w_s) begin
                            s_bvalid_r <= 1'b1;
                            s_bresp_r  <= RESP_DECERR;
                            state_r    <= ST_RESP_W;
                        end else begin
                            s_rvalid_r <= 1'b1;
                            s_rresp_r  <= RESP_DECERR;
                            s_rdata_r  <= 32'h0000_0000;
                            state_r    <= ST_RESP_R;
                        end
                    end
                end
                ST_SETUP: begin
                    m_penable_r <= 1'b1;
                    state_r     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_s || timeout_hit_s) begin
                        m_psel_r    <= '0;
                        m_penable_r <= 1'b0;
                        if (m_pwrite_r) begin
                            s_bvalid_r <= 1'b1;
                            s_bresp_r  <= acc_resp_s;
                            state_r    <= ST_RESP_W;
                        end else begin
                            s_rvalid_r <= 1'b1;
                            s_rresp_r  <= acc_resp_s;
                            s_rdata_r  <= pready_s ? prdata_s : 32'h0000_0000;
                            state_r    <= ST_RESP_R;
                        end
                    end
                end
                ST_RESP_W: begin
                    if (s_bready) begin
                        s_bvalid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_RESP_R: begin
                    if (s_rready) begin
                        s_rvalid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    m_psel_r    <= '0;
                    m_penable_r <= 1'b0;
                    s_bvalid_r  <= 1'b0;
                    s_rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_awready = grant_w_s;
    assign s_wready  = grant_w_s;
    assign s_arready = grant_r_s;
    assign s_bvalid  = s_bvalid_r;
    assign s_bresp   = s_bresp_r;
    assign s_rvalid  = s_rvalid_r;
    assign s_rresp   = s_rresp_r;
    assign s_rdata   = s_rdata_r;
    assign m_paddr   = m_paddr_r;
    assign m_pprot   = m_pprot_r;
    assign m_psel    = m_psel_r;
    assign m_penable = m_penable_r;
    assign m_pwrite  = m_pwrite_r;
    assign m_pwdata  = m_pwdata_r;
    assign m_pstrb   = m_pstrb_r;

endmodule

// File: tb/tb_axil_apb_bridge_n.sv
// Self-checking bench for axil_apb_bridge_n: directed cases plus randomized
// transactions compared against a transaction-level reference model.
// Build with AXIL_APB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_axil_apb_bridge_n;

    localparam int N      = 8;
    localparam int TB_TMO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0]     s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]      s_awprot, s_arprot;
    logic [3:0]      s_wstrb;
    logic            s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]      s_bresp, s_rresp;
    logic [31:0]     m_paddr, m_pwdata;
    logic [2:0]      m_pprot;
    logic [N-1:0]    m_psel, m_pready, m_pslverr;
    logic            m_penable, m_pwrite;
    logic [3:0]      m_pstrb;
    logic [32*N-1:0] m_prdata;

    int              n_cmp = 0;
    int              n_bad = 0;
    bit              ref_last_write = 1'b1;
    logic [31:0]     slv_data [N];
    int              cfg_wait = 0;
    bit              cfg_err = 1'b0;
    int              wcnt = 0;
    bit              tmo_on;

    always #5 clk = ~clk;

    axil_apb_bridge_n #(.SLV_NUM(N), .TIMEOUT_CYC(TB_TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_paddr(m_paddr), .m_pprot(m_pprot), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
    );

    // APB slave models: fixed per-slave read data, error flag for the selected slave
    // and garbage completion signals on every unselected slave.
    for (genvar g = 0; g < N; g++) begin : g_slv
        assign m_prdata[32*g +: 32] = slv_data[g];
    end
    assign m_pslverr = cfg_err ? {N{1'b1}} : ~m_psel;

    // Selected slave inserts cfg_wait wait states; unselected slaves hold PREADY high.
    always @(negedge clk) begin
        bit hit;
        if ((m_psel != '0) && m_penable) begin
            hit  = (wcnt == cfg_wait);
            wcnt = wcnt + 1;
        end else begin
            hit  = 1'b0;
            wcnt = 0;
        end
        m_pready = ~m_psel | (m_psel & {N{hit}});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference address map: eight 4 KiB windows from 0x0300_0000.
    function automatic int ref_slave(input logic [31:0] a);
        if (a >= 32'h0300_0000 && a < 32'h0300_8000) return int'((a - 32'h0300_0000) >> 12);
        return -1;
    endfunction

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 4) == 0) return $urandom;
        return 32'h0300_0000 + 32'($urandom_range(0, 7) << 12) + 32'($urandom_range(0, 1023) << 2);
    endfunction

    task automatic new_slave_data();
        for (int i = 0; i < N; i++) slv_data[i] = $urandom;
    endtask

    task automatic drive_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_awprot = p;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
    endtask

    task automatic drive_r(input logic [31:0] a, input logic [2:0] p);
        s_araddr = a; s_arprot = p; s_arvalid = 1'b1;
    endtask

    // Wait for the address handshake and check which channel was accepted.
    task automatic grab(input bit exp_write);
        logic [2:0] rdy;
        rdy = 3'b000;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = {s_awready, s_wready, s_arready};
            if (rdy != 3'b000) break;
        end
        check("grant", 64'(rdy), exp_write ? 64'(3'b110) : 64'(3'b001));
        ref_last_write = exp_write;
        @(posedge clk); #1;
        if (exp_write) begin
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end else begin
            s_arvalid = 1'b0;
        end
    endtask

    // Follow one accepted transaction to its response and check it against the model.
    task automatic complete(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p, input int bdelay);
        int          idx, acc, exp_lat, exp_psel, n, pc;
        bit          timed;
        logic [1:0]  exp_resp, resp;
        logic [31:0] exp_rdata, held;
        logic [N-1:0] one, exp_sel;
        idx   = ref_slave(a);
        timed = tmo_on && (cfg_wait >= TB_TMO);
        acc   = timed ? TB_TMO : cfg_wait + 1;
        one   = 1;
        exp_sel   = (idx >= 0) ? (one << idx) : '0;
        exp_lat   = (idx < 0) ? 1 : 2 + acc;
        exp_psel  = (idx < 0) ? 0 : 1 + acc;
        exp_resp  = (idx < 0) ? 2'b11 : ((timed || cfg_err) ? 2'b10 : 2'b00);
        exp_rdata = (idx < 0 || timed) ? 32'h0 : slv_data[idx];
        n = 1; pc = 0;
        forever begin
            @(negedge clk);
            check("busy_ready", 64'({s_awready, s_wready, s_arready}), 64'(0));
            if (m_psel != '0) begin
                pc++;
                check("psel", 64'(m_psel), 64'(exp_sel));
                check("apb_req", 64'({m_paddr, m_pwrite, m_pstrb, m_pprot, m_penable}),
                      64'({a, wr, (wr ? s : 4'h0), p, (pc > 1)}));
                if (wr) check("pwdata", 64'(m_pwdata), 64'(d));
            end
            if ((wr ? s_bvalid : s_rvalid) || n >= 200) break;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("psel_cycles", 64'(pc), 64'(exp_psel));
        resp = wr ? s_bresp : s_rresp;
        check("resp", 64'(resp), 64'(exp_resp));
        check("other_valid", 64'(wr ? s_rvalid : s_bvalid), 64'(0));
        if (!wr) check("rdata", 64'(s_rdata), 64'(exp_rdata));
        held = s_rdata;
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            check("resp_hold", 64'({(wr ? s_bvalid : s_rvalid), resp, held}),
                  64'({1'b1, (wr ? s_bresp : s_rresp), s_rdata}));
        end
        if (wr) s_bready = 1'b1; else s_rready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        check("valid_drop", 64'({s_bvalid, s_rvalid}), 64'(0));
    endtask

    task automatic single(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input int wt, input bit err, input int bdelay);
        new_slave_data();
        cfg_wait = wt; cfg_err = err;
        if (wr) drive_w(a, d, s, p); else drive_r(a, p);
        grab(wr);
        complete(wr, a, d, s, p, bdelay);
    endtask

    // Both channels request together; the model predicts the first grant.
    task automatic contest(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input logic [31:0] ra, input int wt);
        bit first;
        new_slave_data();
        cfg_wait = wt; cfg_err = 1'b0;
        drive_w(wa, wd, ws, 3'b010);
        drive_r(ra, 3'b001);
        first = !ref_last_write;
        grab(first);
        if (first) complete(1'b1, wa, wd, ws, 3'b010, 0); else complete(1'b0, ra, 32'h0, 4'h0, 3'b001, 0);
        grab(!first);
        if (!first) complete(1'b1, wa, wd, ws, 3'b010, 0); else complete(1'b0, ra, 32'h0, 4'h0, 3'b001, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] edge_addr [6];
`ifdef AXIL_APB_TIMEOUT_EN
        tmo_on = 1'b1;
`else
        tmo_on = 1'b0;
`endif
        for (int i = 0; i < N; i++) slv_data[i] = 32'h0;
        m_pready = '0;
        rst_n = 1'b0;
        drive_w(32'h0300_0000, 32'h1, 4'hF, 3'b111);
        drive_r(32'h0300_0000, 3'b111);
        s_bready = 1'b1; s_rready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
                               m_penable, m_pwrite, m_pstrb, m_pprot, m_psel}), 64'(0));
        check("rst_data", 64'({s_rdata, m_paddr}), 64'(0));
        check("rst_pwdata", 64'(m_pwdata), 64'(0));
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b0; s_rready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        single(1'b1, 32'h0300_2004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 0);
        single(1'b0, 32'h0300_0010, 32'h0, 4'h0, 3'b000, 3, 1'b0, 1);
        single(1'b0, 32'h0400_0000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 0);
        single(1'b1, 32'h0300_5100, 32'h0BAD_F00D, 4'h3, 3'b011, 1, 1'b1, 2);
        single(1'b1, 32'h1234_5678, 32'h5555_AAAA, 4'h8, 3'b100, 0, 1'b0, 1);
        single(1'b0, 32'h0300_6000, 32'h0, 4'h0, 3'b101, 2, 1'b1, 0);

        edge_addr[0] = 32'h0300_0FFF; edge_addr[1] = 32'h0300_1000; edge_addr[2] = 32'h02FF_FFFF;
        edge_addr[3] = 32'h0300_7FFF; edge_addr[4] = 32'h0300_8000; edge_addr[5] = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) single(1'(i % 2), edge_addr[i], $urandom, 4'(i + 1), 3'(i), 0, 1'b0, 0);

`ifdef AXIL_APB_TIMEOUT_EN
        single(1'b0, 32'h0300_3000, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 0);
        single(1'b0, 32'h0300_3004, 32'h0, 4'h0, 3'b000, TB_TMO - 1, 1'b0, 0);
        single(1'b1, 32'h0300_4008, 32'hCAFE_0001, 4'hF, 3'b000, 1000, 1'b0, 0);
`endif

        // Reset pulse while a read sits in ACCESS.
        new_slave_data();
        cfg_wait = 20; cfg_err = 1'b0;
        drive_r(32'h0300_1008, 3'b000);
        grab(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_access", 64'({m_psel, m_penable}), 64'({8'b0000_0010, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("async_rst", 64'({m_psel, m_penable, s_rvalid, s_bvalid}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        ref_last_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_aborted_resp", 64'({s_rvalid, s_bvalid, m_psel}), 64'(0));
        end
        @(posedge clk); #1;

        for (int r = 0; r < 4; r++) contest(32'h0300_0000 + 32'(r << 12), $urandom, 4'hF, 32'h0300_7000 + 32'(r << 2), r);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                contest(rnd_addr(), $urandom, 4'($urandom), rnd_addr(), $urandom_range(0, 4));
            end else begin
                single(1'($urandom), rnd_addr(), $urandom, 4'($urandom), 3'($urandom),
                       $urandom_range(0, 4), 1'($urandom), $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
